// File: rtl/stats_accum_ram.sv
`default_nettype none
// ============================================================================
//  Module   : stats_accum_ram
//  Brief    : Array of N = 2**STAT_ID_WIDTH statistics counters. Increments
//             arrive on an AXI-stream style port and are applied by a 2-stage
//             read-modify-write with forwarding; a register read port returns
//             counter values two cycles after the request. After reset an
//             INIT sweep clears every entry before traffic is accepted.
//  Options  : define STATS_ACCUM_CLEAR_ON_READ_EN to make reads destructive
//             (the read value is returned and the entry is cleared atomically).
//  Revision : 1.0 - initial release
// ============================================================================
module stats_accum_ram #(
    parameter int STAT_INC_WIDTH   = 24,
    parameter int STAT_ID_WIDTH    = 5,
    parameter int STAT_COUNT_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [STAT_INC_WIDTH-1:0]   s_axis_stat_tdata,
    input  logic [STAT_ID_WIDTH-1:0]    s_axis_stat_tid,
    input  logic                        s_axis_stat_tvalid,
    output logic                        s_axis_stat_tready,
    input  logic [STAT_ID_WIDTH-1:0]    reg_rd_addr,
    input  logic                        reg_rd_en,
    output logic [STAT_COUNT_WIDTH-1:0] reg_rd_data,
    output logic                        reg_rd_ack,
    output logic                        init_done
);

    localparam int N = 2 ** STAT_ID_WIDTH;

`ifdef STATS_ACCUM_CLEAR_ON_READ_EN
    localparam bit CLEAR_ON_READ = 1'b1;
`else
    localparam bit CLEAR_ON_READ = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Control state
    state_t                      state_q,  state_d;
    logic [STAT_ID_WIDTH-1:0]    sweep_q,  sweep_d;

    // Stage 1: operation accepted last cycle, reads the array this cycle
    logic                        s1_valid_q, s1_valid_d;
    logic                        s1_rd_q,    s1_rd_d;
    logic [STAT_ID_WIDTH-1:0]    s1_id_q,    s1_id_d;
    logic [STAT_COUNT_WIDTH-1:0] s1_inc_q,   s1_inc_d;

    // Stage 2: holds the current value, writes the array back this cycle
    logic                        s2_valid_q, s2_valid_d;
    logic                        s2_rd_q,    s2_rd_d;
    logic [STAT_ID_WIDTH-1:0]    s2_id_q,    s2_id_d;
    logic [STAT_COUNT_WIDTH-1:0] s2_inc_q,   s2_inc_d;
    logic [STAT_COUNT_WIDTH-1:0] s2_val_q,   s2_val_d;

    // Read response registers
    logic                        rd_ack_q,   rd_ack_d;
    logic [STAT_COUNT_WIDTH-1:0] rd_data_q,  rd_data_d;

    // Counter storage: one operation is admitted per cycle; its read happens
    // in stage 1 and its write-back in stage 2.
    logic [STAT_COUNT_WIDTH-1:0] mem [N];

    logic                        w_run;
    logic                        w_rd_accept;
    logic                        w_inc_accept;
    logic [STAT_COUNT_WIDTH-1:0] w_mem_rdata;
    logic [STAT_COUNT_WIDTH-1:0] w_s2_wdata;
    logic                        w_s2_we;
    logic [STAT_COUNT_WIDTH-1:0] w_s1_val;
    logic                        w_mem_we;
    logic [STAT_ID_WIDTH-1:0]    w_mem_waddr;
    logic [STAT_COUNT_WIDTH-1:0] w_mem_wdata;

    assign w_run        = (state_q == ST_RUN);
    assign w_rd_accept  = w_run && reg_rd_en;
    assign w_inc_accept = w_run && !reg_rd_en && s_axis_stat_tvalid;

    assign s_axis_stat_tready = w_run && !reg_rd_en;
    assign init_done          = w_run;
    assign reg_rd_ack         = rd_ack_q;
    assign reg_rd_data        = rd_data_q;

    assign w_mem_rdata = mem[s1_id_q];

    // Stage-2 write-back value and enable; non-destructive reads leave the array untouched
    always_comb begin
        w_s2_wdata = s2_val_q + s2_inc_q;
        w_s2_we    = s2_valid_q && (!s2_rd_q || CLEAR_ON_READ);
        if (s2_rd_q) begin
            w_s2_wdata = CLEAR_ON_READ ? '0 : s2_val_q;
        end
    end

    // Stage-1 value, forwarding the stage-2 result when both target the same entry
    always_comb begin
        w_s1_val = w_mem_rdata;
        if (s2_valid_q && (s2_id_q == s1_id_q)) begin
            w_s1_val = w_s2_wdata;
        end
    end

    // Array write port: clear sweep during INIT, stage-2 write-back during RUN
    always_comb begin
        w_mem_we    = w_s2_we;
        w_mem_waddr = s2_id_q;
        w_mem_wdata = w_s2_wdata;
        if (state_q == ST_INIT) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = sweep_q;
            w_mem_wdata = '0;
        end
    end

    // Next-state logic for FSM, pipeline and read response
    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        if (state_q == ST_INIT) begin
            sweep_d = sweep_q + 1'b1;
            if (&sweep_q) begin
                state_d = ST_RUN;
            end
        end

        s1_valid_d = w_rd_accept || w_inc_accept;
        s1_rd_d    = w_rd_accept;
        s1_id_d    = w_rd_accept ? reg_rd_addr : s_axis_stat_tid;
        s1_inc_d   = STAT_COUNT_WIDTH'(s_axis_stat_tdata);

        s2_valid_d = s1_valid_q;
        s2_rd_d    = s1_rd_q;
        s2_id_d    = s1_id_q;
        s2_inc_d   = s1_inc_q;
        s2_val_d   = w_s1_val;

        rd_ack_d   = s1_valid_q && s1_rd_q;
        rd_data_d  = rd_ack_d ? w_s1_val : rd_data_q;
    end

    // Control, pipeline and response registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            sweep_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_rd_q    <= 1'b0;
            s1_id_q    <= '0;
            s1_inc_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_rd_q    <= 1'b0;
            s2_id_q    <= '0;
            s2_inc_q   <= '0;
            s2_val_q   <= '0;
            rd_ack_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            s1_valid_q <= s1_valid_d;
            s1_rd_q    <= s1_rd_d;
            s1_id_q    <= s1_id_d;
            s1_inc_q   <= s1_inc_d;
            s2_valid_q <= s2_valid_d;
            s2_rd_q    <= s2_rd_d;
            s2_id_q    <= s2_id_d;
            s2_inc_q   <= s2_inc_d;
            s2_val_q   <= s2_val_d;
            rd_ack_q   <= rd_ack_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Counter array write; contents are defined by the INIT sweep, not by reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

endmodule
`default_nettype wire
